// File: rtl/xc_lag_engine.sv
// xc_lag_engine: multi-bit, multi-lag auto/cross correlator with double-buffered snapshot and valid/ready readout.
// Optional macro XC_SATURATE_EN: accumulators clamp at the signed limits instead of wrapping.
module xc_lag_engine #(
  parameter int NUM_INPUTS = 4,
  parameter int LAG_SIZE   = 8,
  parameter int WORD_WIDTH = 1,
  parameter int RESOLUTION = 24,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                             smpclk,
  input  logic                             reset,
  input  logic [NUM_INPUTS*WORD_WIDTH-1:0] sample_in,
  input  logic                             sample_valid,
  input  logic [LEN_WIDTH-1:0]             integ_len,
  output logic [RESOLUTION-1:0]            rd_data,
  output logic                             rd_valid,
  input  logic                             rd_ready,
  output logic                             rd_last,
  output logic                             overrun,
  output logic                             overflow
);

  localparam int NB    = NUM_INPUTS * (NUM_INPUTS + 1) / 2;
  localparam int NW    = NB * LAG_SIZE;
  localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
`ifdef XC_SATURATE_EN
  localparam logic [RESOLUTION-1:0] ACC_MAX = {1'b0, {(RESOLUTION-1){1'b1}}};
  localparam logic [RESOLUTION-1:0] ACC_MIN = {1'b1, {(RESOLUTION-1){1'b0}}};
`endif

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA} rd_state_t;

  rd_state_t              state, state_next;
  logic [IDX_W-1:0]       rd_idx, rd_idx_next;

  logic [WORD_WIDTH-1:0]  x    [NUM_INPUTS];
  logic [WORD_WIDTH-1:0]  dly  [NUM_INPUTS][LAG_SIZE-1];
  logic                   fill [NUM_INPUTS][LAG_SIZE-1];

  logic [LEN_WIDTH-1:0]   cnt, len_q, cur_len;
  logic                   accept, is_last;

  logic [RESOLUTION-1:0]  prod_d [NW];
  logic [RESOLUTION-1:0]  prod_q [NW];
  logic                   prod_vld, prod_last, prod_first;

  logic [RESOLUTION-1:0]  acc  [NW];
  logic [RESOLUTION-1:0]  sum  [NW];
  logic [RESOLUTION-1:0]  snap [NW];
  logic [RESOLUTION:0]    wide;
  logic                   ovf_any;
  logic [RESOLUTION-1:0]  frame_cnt, hdr_q;
  logic                   snap_take;

  // 1-bit samples map to +/-1, so their product is +1 when equal and -1 otherwise.
  function automatic logic [RESOLUTION-1:0] mult(input logic [WORD_WIDTH-1:0] u,
                                                 input logic [WORD_WIDTH-1:0] v);
    logic signed [2*WORD_WIDTH-1:0] p;
    p = $signed(u) * $signed(v);
    if (WORD_WIDTH == 1) return (u == v) ? RESOLUTION'(1) : '1;
    return RESOLUTION'(p);
  endfunction

  always_comb begin
    for (int a = 0; a < NUM_INPUTS; a++) x[a] = sample_in[a*WORD_WIDTH +: WORD_WIDTH];
  end

  // Integration length is taken live until the first sample of a frame, then held.
  assign cur_len = (cnt == '0) ? integ_len : len_q;
  assign accept  = sample_valid && (cur_len != '0);
  assign is_last = (cnt + LEN_WIDTH'(1)) == cur_len;

  always_comb begin
    int n;
    n = 0;
    prod_d = '{default: '0};
    for (int a = 0; a < NUM_INPUTS; a++) begin
      for (int b = a; b < NUM_INPUTS; b++) begin
        prod_d[n] = mult(x[a], x[b]);
        n++;
        for (int k = 1; k < LAG_SIZE; k++) begin
          prod_d[n] = fill[b][k-1] ? mult(x[a], dly[b][k-1]) : '0;
          n++;
        end
      end
    end
  end

  always_ff @(posedge smpclk) begin
    if (reset) begin
      cnt        <= '0;
      len_q      <= '0;
      prod_vld   <= 1'b0;
      prod_last  <= 1'b0;
      prod_first <= 1'b0;
      prod_q     <= '{default: '0};
      dly        <= '{default: '0};
      fill       <= '{default: '0};
    end else begin
      prod_vld   <= accept;
      prod_last  <= accept && is_last;
      prod_first <= accept && (cnt == '0);
      if (accept) begin
        prod_q <= prod_d;
        if (cnt == '0) len_q <= integ_len;
        cnt <= is_last ? '0 : cnt + LEN_WIDTH'(1);
        for (int b = 0; b < NUM_INPUTS; b++) begin
          dly[b][0]  <= x[b];
          fill[b][0] <= 1'b1;
          for (int j = 1; j < LAG_SIZE-1; j++) begin
            dly[b][j]  <= dly[b][j-1];
            fill[b][j] <= fill[b][j-1];
          end
        end
      end
    end
  end

  // One extra bit exposes signed overflow regardless of wrap/clamp mode.
  always_comb begin
    ovf_any = 1'b0;
    wide    = '0;
    sum     = '{default: '0};
    for (int i = 0; i < NW; i++) begin
      wide = {acc[i][RESOLUTION-1], acc[i]} + {prod_q[i][RESOLUTION-1], prod_q[i]};
      if (wide[RESOLUTION] != wide[RESOLUTION-1]) ovf_any = 1'b1;
`ifdef XC_SATURATE_EN
      if (wide[RESOLUTION] != wide[RESOLUTION-1])
        sum[i] = wide[RESOLUTION] ? ACC_MIN : ACC_MAX;
      else
        sum[i] = wide[RESOLUTION-1:0];
`else
      sum[i] = wide[RESOLUTION-1:0];
`endif
    end
  end

  assign snap_take = prod_vld && prod_last && (state == S_IDLE);

  always_ff @(posedge smpclk) begin
    if (reset) begin
      acc       <= '{default: '0};
      snap      <= '{default: '0};
      hdr_q     <= '0;
      frame_cnt <= '0;
      overrun   <= 1'b0;
      overflow  <= 1'b0;
    end else if (prod_vld) begin
      overflow <= (overflow & ~prod_first) | ovf_any;
      if (prod_last) begin
        acc       <= '{default: '0};
        frame_cnt <= frame_cnt + RESOLUTION'(1);
        if (state == S_IDLE) begin
          snap  <= sum;
          hdr_q <= frame_cnt;
        end else begin
          overrun <= 1'b1;
        end
      end else begin
        acc <= sum;
      end
    end
  end

  always_ff @(posedge smpclk) begin
    if (reset) begin
      state  <= S_IDLE;
      rd_idx <= '0;
    end else begin
      state  <= state_next;
      rd_idx <= rd_idx_next;
    end
  end

  always_comb begin
    state_next  = state;
    rd_idx_next = rd_idx;
    rd_valid    = 1'b0;
    rd_last     = 1'b0;
    rd_data     = '0;
    case (state)
      S_IDLE: begin
        if (snap_take) state_next = S_HEADER;
      end
      S_HEADER: begin
        rd_valid = 1'b1;
        rd_data  = hdr_q;
        if (rd_ready) begin
          state_next  = S_DATA;
          rd_idx_next = '0;
        end
      end
      S_DATA: begin
        rd_valid = 1'b1;
        rd_data  = snap[rd_idx];
        rd_last  = (rd_idx == IDX_W'(NW-1));
        if (rd_ready) begin
          if (rd_last) state_next = S_IDLE;
          else rd_idx_next = rd_idx + IDX_W'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule
